// File: rtl/huffman_pkg.sv
// Shared constants for the Huffman bit buffer and its downstream decoder.
package huffman_pkg;

  localparam int MAX_CODE = 9;
  localparam int IN_W     = 4;
  localparam int LEN_W    = 3;
  localparam int CNT_W    = 4;
  localparam int DEPTH    = 12;

  function automatic logic len_legal(input logic [LEN_W-1:0] len);
    return (len != '0) && (len <= LEN_W'(IN_W));
  endfunction

  // Low-order mask of len ones; len==IN_W wraps to all ones.
  function automatic logic [IN_W-1:0] len_mask(input logic [LEN_W-1:0] len);
    logic [IN_W:0] one_hot;
    one_hot = (IN_W+1)'(1) << len;
    return one_hot[IN_W-1:0] - IN_W'(1);
  endfunction

endpackage

// File: rtl/huffman_bit_buffer.sv
// Accumulates 1-4 bit beats into an MSB-aligned store and presents the oldest
// MAX_CODE bits to the decoder; one hold slot, one-edge shift/append, sticky errors.
module huffman_bit_buffer #(
  parameter int MAX_CODE = huffman_pkg::MAX_CODE,
  parameter int DEPTH    = huffman_pkg::DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          svalid,
  input  logic [huffman_pkg::IN_W-1:0]  in_data,
  input  logic [huffman_pkg::LEN_W-1:0] in_len,
  input  logic                          aready,
  input  logic                          load_bits,
  input  logic                          shift_en,
  input  logic [huffman_pkg::CNT_W-1:0] shift_len,
  input  logic                          flush,
  output logic [MAX_CODE-1:0]           shift_buf,
  output logic [huffman_pkg::CNT_W-1:0] bit_count,
  output logic                          hold_valid,
  output logic                          overflow_err,
  output logic                          underflow_err,
  output logic                          len_err
);
  import huffman_pkg::*;

  localparam int CW1 = CNT_W + 1;
  localparam logic [CNT_W:0] DEPTH_X = CW1'(DEPTH);

  logic [DEPTH-1:0] store_q, store_d, shifted, placed;
  logic [CNT_W-1:0] count_q, count_d, shifted_cnt;
  logic [CNT_W:0]   fill;
  logic             hold_valid_q, hold_valid_d;
  logic [IN_W-1:0]  hold_data_q, hold_data_d;
  logic [LEN_W-1:0] hold_len_q, hold_len_d;
  logic             ovf_q, ovf_d, udf_q, udf_d, lenerr_q, lenerr_d;
  logic             xfer, append;

  always_comb begin
    xfer         = svalid && aready;
    append       = load_bits && hold_valid_q;
    ovf_d        = ovf_q;
    udf_d        = udf_q;
    lenerr_d     = lenerr_q;
    hold_data_d  = hold_data_q;
    hold_len_d   = hold_len_q;

    shifted     = store_q;
    shifted_cnt = count_q;
    if (shift_en && (shift_len != '0)) begin
      if (shift_len > count_q) begin
        shifted     = '0;
        shifted_cnt = '0;
        udf_d       = 1'b1;
      end else begin
        shifted     = store_q << shift_len;
        shifted_cnt = count_q - shift_len;
      end
    end

    // Held bits land directly below the post-shift valid bits.
    fill    = {1'b0, shifted_cnt} + CW1'(hold_len_q);
    placed  = DEPTH'({hold_data_q, {DEPTH{1'b0}}} >> fill);
    store_d = shifted;
    count_d = shifted_cnt;
    if (append) begin
      if (fill > DEPTH_X) begin
        ovf_d = 1'b1;
      end else begin
        store_d = shifted | placed;
        count_d = fill[CNT_W-1:0];
      end
    end

    hold_valid_d = hold_valid_q && !load_bits;
    if (xfer) begin
      if (!len_legal(in_len)) begin
        lenerr_d = 1'b1;
      end else begin
        if (hold_valid_q && !load_bits) ovf_d = 1'b1;
        hold_valid_d = 1'b1;
        hold_data_d  = in_data & len_mask(in_len);
        hold_len_d   = in_len;
      end
    end

    // Flush drops everything in flight but leaves the sticky flags untouched.
    if (flush) begin
      store_d      = '0;
      count_d      = '0;
      hold_valid_d = 1'b0;
      ovf_d        = ovf_q;
      udf_d        = udf_q;
      lenerr_d     = lenerr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      hold_len_q   <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      hold_len_q   <= hold_len_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      store_q  <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      lenerr_q <= 1'b0;
    end else begin
      store_q  <= store_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      lenerr_q <= lenerr_d;
    end
  end

  assign shift_buf     = store_q[DEPTH-1 -: MAX_CODE];
  assign bit_count     = count_q;
  assign hold_valid    = hold_valid_q;
  assign overflow_err  = ovf_q;
  assign underflow_err = udf_q;
  assign len_err       = lenerr_q;

endmodule

// File: tb/tb_huffman_bit_buffer.sv
// Directed vector table plus hand-written multi-cycle sequences for huffman_bit_buffer.
module tb_huffman_bit_buffer;

  logic       clk = 1'b0;
  logic       reset, svalid, aready, load_bits, shift_en, flush;
  logic [3:0] in_data, shift_len, bit_count;
  logic [2:0] in_len;
  logic [8:0] shift_buf;
  logic       hold_valid, overflow_err, underflow_err, len_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  huffman_bit_buffer dut (
    .clk(clk), .reset(reset), .svalid(svalid), .in_data(in_data), .in_len(in_len),
    .aready(aready), .load_bits(load_bits), .shift_en(shift_en), .shift_len(shift_len),
    .flush(flush), .shift_buf(shift_buf), .bit_count(bit_count), .hold_valid(hold_valid),
    .overflow_err(overflow_err), .underflow_err(underflow_err), .len_err(len_err)
  );

  typedef struct {
    logic       rst, fl, sv, ar, ld, se;
    logic [3:0] d;
    logic [2:0] l;
    logic [3:0] sl;
    logic [8:0] eb;
    logic [3:0] ec;
    logic       eh, eo, eu, el;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, fl, sv, ar, ld, se, input logic [3:0] d,
                     input logic [2:0] l, input logic [3:0] sl, input logic [8:0] eb,
                     input logic [3:0] ec, input logic eh, eo, eu, el);
    vec_t v;
    v.rst = rst; v.fl = fl; v.sv = sv; v.ar = ar; v.ld = ld; v.se = se;
    v.d = d; v.l = l; v.sl = sl; v.eb = eb; v.ec = ec;
    v.eh = eh; v.eo = eo; v.eu = eu; v.el = el;
    vecs.push_back(v);
  endtask

  task automatic step(input logic rst, fl, sv, ar, ld, se, input logic [3:0] d,
                      input logic [2:0] l, input logic [3:0] sl);
    @(negedge clk);
    reset = rst; flush = fl; svalid = sv; aready = ar; load_bits = ld;
    shift_en = se; in_data = d; in_len = l; shift_len = sl;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [16:0] got, input logic [16:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got buf/cnt/hv/ov/uf/le=%b required %b", name, got, exp);
    end
  endtask

  function automatic logic [16:0] outs();
    return {shift_buf, bit_count, hold_valid, overflow_err, underflow_err, len_err};
  endfunction

  initial begin
    reset = 1'b1; flush = 1'b0; svalid = 1'b0; aready = 1'b0; load_bits = 1'b0;
    shift_en = 1'b0; in_data = '0; in_len = '0; shift_len = '0;

    //  rst fl sv ar ld se  d        l     sl     exp buf         cnt  h  o  u  e
    add(1, 0, 0, 0, 0, 0, 4'b0000, 3'd0, 4'd0, 9'b000000000, 4'd0,  0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0, 4'b0101, 3'd3, 4'd0, 9'b000000000, 4'd0,  1, 0, 0, 0);
    add(0, 0, 1, 1, 1, 0, 4'b0001, 3'd1, 4'd0, 9'b101000000, 4'd3,  1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 4'b0000, 3'd0, 4'd0, 9'b101100000, 4'd4,  0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 4'b0000, 3'd0, 4'd3, 9'b100000000, 4'd1,  0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0, 4'b0011, 3'd3, 4'd0, 9'b100000000, 4'd1,  1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 4'b0000, 3'd0, 4'd0, 9'b101100000, 4'd4,  0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0, 4'b1101, 3'd2, 4'd0, 9'b101100000, 4'd4,  1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 4'b0000, 3'd0, 4'd1, 9'b011010000, 4'd5,  0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0, 4'b1111, 3'd4, 4'd0, 9'b011010000, 4'd5,  1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 4'b0000, 3'd0, 4'd0, 9'b011011111, 4'd9,  0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0, 4'b0010, 3'd2, 4'd0, 9'b011011111, 4'd9,  1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 4'b0000, 3'd0, 4'd0, 9'b011011111, 4'd11, 0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0, 4'b1010, 3'd4, 4'd0, 9'b011011111, 4'd11, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 4'b0000, 3'd0, 4'd0, 9'b011011111, 4'd11, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 4'b0000, 3'd0, 4'd9, 9'b100000000, 4'd2,  0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 4'b0000, 3'd0, 4'd5, 9'b000000000, 4'd0,  0, 1, 1, 0);
    add(0, 0, 1, 1, 0, 0, 4'b1111, 3'd0, 4'd0, 9'b000000000, 4'd0,  0, 1, 1, 1);
    add(0, 0, 1, 1, 0, 0, 4'b1111, 3'd5, 4'd0, 9'b000000000, 4'd0,  0, 1, 1, 1);
    add(0, 0, 1, 1, 0, 0, 4'b1100, 3'd4, 4'd0, 9'b000000000, 4'd0,  1, 1, 1, 1);
    add(0, 0, 1, 1, 1, 0, 4'b0101, 3'd3, 4'd0, 9'b110000000, 4'd4,  1, 1, 1, 1);
    add(0, 0, 1, 1, 1, 0, 4'b0011, 3'd3, 4'd0, 9'b110010100, 4'd7,  1, 1, 1, 1);
    add(0, 1, 0, 0, 0, 0, 4'b0000, 3'd0, 4'd0, 9'b000000000, 4'd0,  0, 1, 1, 1);
    add(1, 0, 0, 0, 0, 0, 4'b0000, 3'd0, 4'd0, 9'b000000000, 4'd0,  0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0, 4'b0001, 3'd1, 4'd0, 9'b000000000, 4'd0,  1, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0, 4'b0000, 3'd1, 4'd0, 9'b000000000, 4'd0,  1, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 4'b0000, 3'd0, 4'd0, 9'b000000000, 4'd1,  0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 4'b0000, 3'd0, 4'd0, 9'b000000000, 4'd1,  0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 4'b0000, 3'd0, 4'd0, 9'b000000000, 4'd1,  0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 4'b0000, 3'd0, 4'd1, 9'b000000000, 4'd0,  0, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 4'b1111, 3'd4, 4'd0, 9'b000000000, 4'd0,  0, 1, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].fl, vecs[i].sv, vecs[i].ar, vecs[i].ld, vecs[i].se,
           vecs[i].d, vecs[i].l, vecs[i].sl);
      chk($sformatf("vec%0d", i), outs(),
          {vecs[i].eb, vecs[i].ec, vecs[i].eh, vecs[i].eo, vecs[i].eu, vecs[i].el});
    end

    // Beat waits in the hold across idle cycles; window only moves on load.
    step(1, 0, 0, 0, 0, 0, 4'b0000, 3'd0, 4'd0);
    chk("seq_reset", outs(), 17'd0);
    step(0, 0, 1, 1, 0, 0, 4'b1001, 3'd4, 4'd0);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 0, 0, 4'b0000, 3'd0, 4'd0);
      chk($sformatf("seq_idle%0d", k), outs(), {9'b0, 4'd0, 1'b1, 3'b000});
    end
    step(0, 0, 0, 0, 1, 0, 4'b0000, 3'd0, 4'd0);
    chk("seq_load", outs(), {9'b100100000, 4'd4, 1'b0, 3'b000});

    // Exact fill to DEPTH is legal and raises no overflow.
    step(0, 0, 1, 1, 0, 0, 4'b1111, 3'd4, 4'd0);
    step(0, 0, 1, 1, 1, 0, 4'b0011, 3'd4, 4'd0);
    chk("seq_fill8", outs(), {9'b100111110, 4'd8, 1'b1, 3'b000});
    step(0, 0, 0, 0, 1, 0, 4'b0000, 3'd0, 4'd0);
    chk("seq_fill12", outs(), {9'b100111110, 4'd12, 1'b0, 3'b000});

    // Shift by the full count leaves an empty store without underflow.
    step(0, 0, 0, 0, 0, 1, 4'b0000, 3'd0, 4'd9);
    chk("seq_shift9", outs(), {9'b011000000, 4'd3, 1'b0, 3'b000});
    step(0, 0, 0, 0, 0, 1, 4'b0000, 3'd0, 4'd3);
    chk("seq_shift_all", outs(), {9'b000000000, 4'd0, 1'b0, 3'b000});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/huffman_bit_buffer.md
# huffman_bit_buffer

Bit-accumulation stage directly upstream of `decoder_fsm`: captures 1–4-bit input beats on the `svalid`/`aready` handshake, stores them in an MSB-aligned shift store, and presents the oldest `MAX_CODE` bits as `shift_buf` with a valid-bit count. It consumes `load_bits`, `shift_en` and `shift_len` from the decoder and retires matched code bits. Sticky error flags report overflow, underflow and illegal beat lengths.

## Interface
- `MAX_CODE`, 9, window width presented to the decoder (longest Huffman code).
- `DEPTH`, 12, storage bits; legal range `MAX_CODE+3` ≤ `DEPTH` ≤ 15, so the count fits in 4 bits.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `svalid`  in  1  input beat valid.
- `in_data`  in  4  beat bits; `in_data[in_len-1]` oldest, `in_data[0]` newest.
- `in_len`  in  3  valid bits in beat; legal values 1–4.
- `aready`  in  1  decoder ready; a beat transfers when `svalid && aready`.
- `load_bits`  in  1  append the held beat to the store.
- `shift_en`  in  1  retire bits from the head.
- `shift_len`  in  4  bits to retire, 0–`MAX_CODE`.
- `flush`  in  1  discard all stored and held bits.
- `shift_buf`  out  `MAX_CODE`  oldest bits, MSB = oldest; unfilled positions 0.
- `bit_count`  out  4  valid bits in the store, 0–`DEPTH`.
- `hold_valid`  out  1  a captured beat awaits `load_bits`.
- `overflow_err`  out  1  sticky.
- `underflow_err`  out  1  sticky.
- `len_err`  out  1  sticky.

## Operation
- Hold register, one entry: on `svalid && aready` with a legal `in_len`, capture `in_data`/`in_len` and set `hold_valid`.
- Illegal `in_len` (0, 5–7) on a transfer: beat not captured; `len_err` set.
- Transfer while `hold_valid` is set and `load_bits` is low: the new beat overwrites the hold; `overflow_err` set.
- Store is MSB-aligned: bit `DEPTH-1` holds the oldest bit.
- Per cycle, in priority order:
  - `reset` clears all state.
  - `flush` zeroes the store, `bit_count` and `hold_valid`; errors are kept.
  - Otherwise a shift is applied, then an append.
- Shift, when `shift_en`:
  - `shift_len` ≤ `bit_count`: store <<= `shift_len`, zero-filled.
  - `shift_len` > `bit_count`: store and count cleared; `underflow_err` set.
  - `shift_len` = 0: no-op.
- Append, when `load_bits && hold_valid`:
  - Held bits go immediately below the post-shift valid bits; count += `in_len`; `hold_valid` clears.
  - Post-shift count + `in_len` > `DEPTH`: the append is dropped, the hold is still consumed, and `overflow_err` is set.
- `load_bits` with the hold empty: no-op, no error.
- Simultaneous `load_bits` and a new transfer: the old hold is appended and the new beat is captured in the same cycle; no error.
- No FSM states beyond the `hold_valid` flag; all behaviour is register updates.

## Timing
- Reset values: `shift_buf`=0, `bit_count`=0, `hold_valid`=0, all error flags 0.
- `shift_buf`, `bit_count`, `hold_valid` and the error flags are registered; each reflects an event on the cycle after the triggering edge.
- Beat-to-window latency: transfer at edge N, `load_bits` sampled at edge N+1 or later, window updated after that edge. Minimum latency is 2 edges.
- Shift latency: 1 edge.
- `flush` or `reset` asserted mid-operation discards the in-flight hold beat with no error.
- `shift_buf` bits below `bit_count` are guaranteed 0.

## Structure
- Shared package `huffman_pkg` holds `MAX_CODE`, `IN_W`=4, `LEN_W`=3, `CNT_W`=4 and the default `DEPTH`; `decoder_fsm` and this block both import it.
- Flat module, no sub-module; the hold register and the store are a single `always` block each.

## Test plan
- Beats `101`/3 then `1`/1, each loaded → `bit_count`=4, `shift_buf`=`9'b101100000`.
- From the 4-bit state above, `shift_en` with `shift_len`=3 → `bit_count`=1, `shift_buf`=`9'b100000000`, no error flag set.
- Same cycle: `shift_en`/`shift_len`=1 on store `1011`, `load_bits` with held `01`/2 → store `01101`, `bit_count`=5.
- Fill to 11 bits, load a held 4-bit beat → append dropped, `bit_count` stays 11, `overflow_err`=1, `hold_valid`=0.
- `shift_len`=5 with `bit_count`=2 → `bit_count`=0, `shift_buf`=0, `underflow_err`=1. Beat with `in_len`=0 → `len_err`=1 and `hold_valid` stays 0.
- `flush` with `bit_count`=7 and the hold full → `bit_count`=0, `hold_valid`=0, sticky errors kept. `reset` for one cycle → all outputs 0.
